// File: rtl/frecuenciometro_gated.sv
// Gated-window frequency meter: counts synchronised rising edges of signal per 1 s / 100 ms gate and publishes once per window.
// Result 1 cycle after window end, edge latency SYNC_FF+1 cycles; no backpressure. FREQ_HOLD_EN adds a hold input freezing outputs.
module frecuenciometro_gated #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int CNT_W   = 23,
  parameter int SYNC_FF = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             signal,
  input  logic             range,
`ifdef FREQ_HOLD_EN
  input  logic             hold,
`endif
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic             ovf,
  output logic             range_out
);

  localparam int GW = $clog2(CLK_HZ);
  localparam logic [GW-1:0]    LAST_1S    = GW'(CLK_HZ - 1);
  localparam logic [GW-1:0]    LAST_100MS = GW'(CLK_HZ / 10 - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  if (CLK_HZ < 10) begin : g_bad_clk_hz
    $error("frecuenciometro_gated: CLK_HZ must be at least 10");
  end
  if (SYNC_FF < 2 || SYNC_FF > 4) begin : g_bad_sync_ff
    $error("frecuenciometro_gated: SYNC_FF must be 2..4");
  end

  logic [SYNC_FF-1:0] sync_q;
  logic               prev_q;
  logic               edge_det;
  logic [GW-1:0]      gate_q;
  logic [CNT_W-1:0]   edge_cnt;
  logic               sat_q;
  logic               range_q;
  logic               gate_last;
  logic               cnt_full;
  logic               hold_now;

`ifdef FREQ_HOLD_EN
  assign hold_now = hold;
`else
  assign hold_now = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_FF-2:0], signal};
      prev_q <= sync_q[SYNC_FF-1];
    end
  end

  assign edge_det  = sync_q[SYNC_FF-1] & ~prev_q;
  assign gate_last = (gate_q == (range_q ? LAST_100MS : LAST_1S));
  assign cnt_full  = (edge_cnt == CNT_MAX);

  // range_q is reloaded during reset so the first window starts cleanly on release
  always_ff @(posedge clk) begin
    if (!rst) begin
      freq       <= '0;
      freq_valid <= 1'b0;
      ovf        <= 1'b0;
      range_out  <= 1'b0;
      gate_q     <= '0;
      edge_cnt   <= '0;
      sat_q      <= 1'b0;
      range_q    <= range;
    end else begin
      freq_valid <= 1'b0;
      if (range != range_q) begin
        gate_q   <= '0;
        edge_cnt <= '0;
        sat_q    <= 1'b0;
        range_q  <= range;
      end else if (gate_last) begin
        gate_q   <= '0;
        edge_cnt <= '0;
        sat_q    <= 1'b0;
        // an edge landing in the terminal cycle still belongs to the closing window
        if (!hold_now) begin
          freq       <= cnt_full ? CNT_MAX : edge_cnt + CNT_W'(edge_det);
          ovf        <= sat_q | (cnt_full & edge_det);
          range_out  <= range_q;
          freq_valid <= 1'b1;
        end
      end else begin
        gate_q <= gate_q + GW'(1);
        if (edge_det) begin
          if (cnt_full) begin
            sat_q <= 1'b1;
          end else begin
            edge_cnt <= edge_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule
